// File: rtl/dmi_jtag_dr.sv
// JTAG DR stage for the DTM: DTMCS and DMI scan registers, plus the tck-domain
// request/response handshake towards the Debug Module.
module dmi_jtag_dr #(
    parameter int unsigned AbitsDmi   = 7,
    parameter int unsigned IdleCycles = 1,
    parameter int unsigned DmiVersion = 1
) (
    input  logic                tck_i,
    input  logic                trst_ni,
    input  logic                tdi_i,
    input  logic                capture_i,
    input  logic                shift_i,
    input  logic                update_i,
    input  logic                dtmcs_select_i,
    input  logic                dmi_select_i,
    input  logic                dmi_clear_i,
    output logic                dtmcs_tdo_o,
    output logic                dmi_tdo_o,
    output logic                dmi_rst_no,
    output logic                dmi_req_valid_o,
    input  logic                dmi_req_ready_i,
    output logic [AbitsDmi-1:0] dmi_req_addr_o,
    output logic [31:0]         dmi_req_data_o,
    output logic [1:0]          dmi_req_op_o,
    input  logic                dmi_resp_valid_i,
    output logic                dmi_resp_ready_o,
    input  logic [31:0]         dmi_resp_data_i,
    input  logic [1:0]          dmi_resp_resp_i
);

    // state     | meaning
    // Idle      | no DMI transaction outstanding
    // Read      | read request presented, waiting for req_ready
    // WaitRead  | read accepted, waiting for response
    // Write     | write request presented, waiting for req_ready
    // WaitWrite | write accepted, waiting for response
    localparam logic [2:0] Idle      = 3'd0;
    localparam logic [2:0] Read      = 3'd1;
    localparam logic [2:0] WaitRead  = 3'd2;
    localparam logic [2:0] Write     = 3'd3;
    localparam logic [2:0] WaitWrite = 3'd4;

    localparam int unsigned DmiWidth = AbitsDmi + 34;

    logic [2:0]          state_q, state_d;
    logic [1:0]          error_q, error_d;
    logic [AbitsDmi-1:0] address_q, address_d;
    logic [31:0]         data_q, data_d;
    logic [31:0]         dtmcs_q, dtmcs_d;
    logic [DmiWidth-1:0] dmi_sr_q, dmi_sr_d;
    logic                dmi_rst_n_q, dmi_rst_n_d;

    logic [31:0]         dtmcs_value;
    logic [AbitsDmi-1:0] sr_addr;
    logic [31:0]         sr_data;
    logic [1:0]          sr_op;

    assign dtmcs_value = {14'd0, 2'b00, 1'b0, 3'(IdleCycles), error_q,
                          6'(AbitsDmi), 4'(DmiVersion)};

    assign sr_addr = dmi_sr_q[DmiWidth-1:34];
    assign sr_data = dmi_sr_q[33:2];
    assign sr_op   = dmi_sr_q[1:0];

    always_comb begin
        state_d     = state_q;
        error_d     = error_q;
        address_d   = address_q;
        data_d      = data_q;
        dtmcs_d     = dtmcs_q;
        dmi_sr_d    = dmi_sr_q;
        dmi_rst_n_d = 1'b1;

        case (state_q)
            Read:  if (dmi_req_ready_i) state_d = WaitRead;
            Write: if (dmi_req_ready_i) state_d = WaitWrite;
            WaitRead, WaitWrite: begin
                if (dmi_resp_valid_i) begin
                    if (state_q == WaitRead) data_d = dmi_resp_data_i;
                    if (dmi_resp_resp_i != 2'b00 && error_q == 2'b00) error_d = 2'b10;
                    state_d = Idle;
                end
            end
            default: state_d = Idle;
        endcase

        // A busy capture flags the sticky error and overrides any response error.
        if (dmi_select_i) begin
            if (capture_i) begin
                if (state_q != Idle) begin
                    error_d  = 2'b11;
                    dmi_sr_d = {address_q, data_q, 2'b11};
                end else begin
                    dmi_sr_d = {address_q, data_q, error_q};
                end
            end else if (shift_i) begin
                dmi_sr_d = {tdi_i, dmi_sr_q[DmiWidth-1:1]};
            end else if (update_i && error_q == 2'b00) begin
                if (state_q != Idle) begin
                    error_d = 2'b11;
                end else if (sr_op == 2'b01) begin
                    address_d = sr_addr;
                    state_d   = Read;
                end else if (sr_op == 2'b10) begin
                    address_d = sr_addr;
                    data_d    = sr_data;
                    state_d   = Write;
                end
            end
        end

        if (dtmcs_select_i) begin
            if (capture_i) begin
                dtmcs_d = dtmcs_value;
            end else if (shift_i) begin
                dtmcs_d = {tdi_i, dtmcs_q[31:1]};
            end else if (update_i) begin
                if (dtmcs_q[17]) begin
                    error_d     = 2'b00;
                    state_d     = Idle;
                    dmi_rst_n_d = 1'b0;
                end else if (dtmcs_q[16]) begin
                    error_d = 2'b00;
                end
            end
        end

        if (dmi_clear_i) begin
            state_d     = Idle;
            error_d     = 2'b00;
            address_d   = '0;
            data_d      = '0;
            dtmcs_d     = '0;
            dmi_sr_d    = '0;
            dmi_rst_n_d = 1'b1;
        end
    end

    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni) begin
            state_q     <= Idle;
            error_q     <= 2'b00;
            address_q   <= '0;
            data_q      <= '0;
            dtmcs_q     <= '0;
            dmi_sr_q    <= '0;
            dmi_rst_n_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            error_q     <= error_d;
            address_q   <= address_d;
            data_q      <= data_d;
            dtmcs_q     <= dtmcs_d;
            dmi_sr_q    <= dmi_sr_d;
            dmi_rst_n_q <= dmi_rst_n_d;
        end
    end

    assign dtmcs_tdo_o      = dtmcs_q[0];
    assign dmi_tdo_o        = dmi_sr_q[0];
    assign dmi_rst_no       = dmi_rst_n_q;
    assign dmi_req_valid_o  = (state_q == Read) || (state_q == Write);
    assign dmi_req_op_o     = (state_q == Read)  ? 2'b01 :
                              (state_q == Write) ? 2'b10 : 2'b00;
    assign dmi_req_addr_o   = address_q;
    assign dmi_req_data_o   = data_q;
    assign dmi_resp_ready_o = (state_q == WaitRead) || (state_q == WaitWrite);

endmodule
